// File: rtl/alu_pipe_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_pipe_pkg : opcode encoding and result record shared by the ALU pipe    |
// | Revision     : 1.0                                                         |
// +----------------------------------------------------------------------------+
package alu_pipe_pkg;

    localparam int c_RES_WIDTH = 8;

    typedef enum logic [2:0] {
        OP_ADD     = 3'b000,
        OP_PASS_A  = 3'b001,
        OP_PASS_B  = 3'b010,
        OP_SUB     = 3'b011,
        OP_XOR     = 3'b100,
        OP_AND     = 3'b101,
        OP_OR      = 3'b110,
        OP_ILLEGAL = 3'b111
    } op_e;

    typedef struct packed {
        logic [c_RES_WIDTH-1:0] o1;
        logic                   carry;
        logic                   zero;
        logic                   illegal;
    } alu_res_t;

endpackage
`default_nettype wire

// File: rtl/alu_pipe_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_pipe_stage : one valid/ready register slot of the ALU pipeline         |
// | Revision       : 1.0                                                       |
// +----------------------------------------------------------------------------+
module alu_pipe_stage
    import alu_pipe_pkg::*;
#(
    parameter int            DW      = 11,
    parameter logic [DW-1:0] RST_VAL = '0
) (
    input  logic          clock,
    input  logic          clear,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);

    logic          r_valid;
    logic [DW-1:0] r_data;

    assign in_ready  = ~r_valid | out_ready;
    assign out_valid = r_valid;
    assign out_data  = r_data;

    // Data is only written on a real load; an emptied slot keeps stale contents.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_valid <= 1'b0;
            r_data  <= RST_VAL;
        end else begin
            if (in_ready) begin
                r_valid <= in_valid;
            end
            if (in_ready && in_valid) begin
                r_data <= in_data;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_pipe : combinational ALU feeding STAGES valid/ready register slots.    |
// |            ALU_PIPE_STATS_EN adds op_count / illegal_count outputs.        |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i2,
    input  logic [2:0]       opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] o1,
    output logic             carry,
    output logic             zero,
    output logic             illegal
`ifdef ALU_PIPE_STATS_EN
    ,
    output logic [31:0]      op_count,
    output logic [15:0]      illegal_count
`endif
);

    // Same layout as alu_res_t, sized to this instance's WIDTH.
    typedef struct packed {
        logic [WIDTH-1:0] o1;
        logic             carry;
        logic             zero;
        logic             illegal;
    } res_t;

    localparam int   c_DW      = $bits(res_t);
    localparam res_t c_RST_RES = '{o1: '0, carry: 1'b0, zero: 1'b1, illegal: 1'b0};

    logic [WIDTH:0] w_wide;
    res_t           w_alu;
    res_t           w_out;
    logic           r_run;

    always_comb begin
        w_wide = '0;
        w_alu  = '0;
        case (op_e'(opcode))
            OP_ADD:     w_wide = {1'b0, i1} + {1'b0, i2};
            OP_PASS_A:  w_wide = {1'b0, i1};
            OP_PASS_B:  w_wide = {1'b0, i2};
            OP_SUB:     w_wide = {1'b0, i1} - {1'b0, i2};
            OP_XOR:     w_wide = {1'b0, i1 ^ i2};
            OP_AND:     w_wide = {1'b0, i1 & i2};
            OP_OR:      w_wide = {1'b0, i1 | i2};
            OP_ILLEGAL: w_alu.illegal = 1'b1;
        endcase
        w_alu.o1    = w_wide[WIDTH-1:0];
        w_alu.carry = w_wide[WIDTH];
        w_alu.zero  = (w_wide[WIDTH-1:0] == '0);
    end

    // Holds in_ready low until the first rising edge after reset release.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_run <= 1'b0;
        end else begin
            r_run <= 1'b1;
        end
    end

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        logic            w_vld_i;
        logic            w_rdy_i;
        logic [c_DW-1:0] w_dat_i;
        logic            w_vld_o;
        logic            w_rdy_o;
        logic [c_DW-1:0] w_dat_o;

        if (gi == 0) begin : g_head
            assign w_vld_i = in_valid & r_run;
            assign w_dat_i = w_alu;
        end else begin : g_body
            assign w_vld_i = g_stage[gi-1].w_vld_o;
            assign w_dat_i = g_stage[gi-1].w_dat_o;
        end

        if (gi == STAGES - 1) begin : g_tail
            assign w_rdy_o = out_ready;
        end else begin : g_link
            assign w_rdy_o = g_stage[gi+1].w_rdy_i;
        end

        alu_pipe_stage #(
            .DW      (c_DW),
            .RST_VAL (c_RST_RES)
        ) u_stage (
            .clock     (clock),
            .clear     (clear),
            .in_valid  (w_vld_i),
            .in_ready  (w_rdy_i),
            .in_data   (w_dat_i),
            .out_valid (w_vld_o),
            .out_ready (w_rdy_o),
            .out_data  (w_dat_o)
        );
    end

    assign in_ready  = r_run & g_stage[0].w_rdy_i;
    assign out_valid = g_stage[STAGES-1].w_vld_o;
    assign w_out     = g_stage[STAGES-1].w_dat_o;
    assign o1        = w_out.o1;
    assign carry     = w_out.carry;
    assign zero      = w_out.zero;
    assign illegal   = w_out.illegal;

`ifdef ALU_PIPE_STATS_EN
    logic w_out_hs;
    assign w_out_hs = out_valid & out_ready;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            op_count      <= '0;
            illegal_count <= '0;
        end else if (w_out_hs) begin
            op_count <= op_count + 32'd1;
            if (illegal && (illegal_count != 16'hFFFF)) begin
                illegal_count <= illegal_count + 16'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_alu_pipe : self-checking bench for alu_pipe (WIDTH=8, STAGES=2)         |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_alu_pipe;
    import alu_pipe_pkg::*;

    localparam int WIDTH  = 8;
    localparam int STAGES = 2;

    logic             clock     = 1'b0;
    logic             clear     = 1'b1;
    logic             in_valid  = 1'b0;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] i1        = '0;
    logic [WIDTH-1:0] i2        = '0;
    logic [2:0]       opcode    = '0;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] o1;
    logic             carry;
    logic             zero;
    logic             illegal;
`ifdef ALU_PIPE_STATS_EN
    logic [31:0]      op_count;
    logic [15:0]      illegal_count;
`endif

    always #5 clock = ~clock;

    alu_pipe #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES)
    ) dut (
        .clock     (clock),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .i1        (i1),
        .i2        (i2),
        .opcode    (opcode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .o1        (o1),
        .carry     (carry),
        .zero      (zero),
        .illegal   (illegal)
`ifdef ALU_PIPE_STATS_EN
        ,
        .op_count      (op_count),
        .illegal_count (illegal_count)
`endif
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
        alu_res_t   ex;
    } vec_t;

    vec_t     tbl [12];
    alu_res_t q [$];
    alu_res_t mon_e;
    int       n_checks = 0;
    int       n_fail   = 0;
    int       n_out    = 0;
    bit       rnd_on   = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string nm);
        n_checks++;
        n_fail++;
        $display("FAIL %s: bound expired at %0t", nm, $time);
    endtask

    // Reference model written from the opcode table with integer arithmetic.
    function automatic alu_res_t model(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        alu_res_t r;
        int       s;
        r = '0;
        case (op)
            3'd0: begin s = int'(a) + int'(b); r.carry = (s > 255); r.o1 = 8'(s % 256); end
            3'd1: r.o1 = a;
            3'd2: r.o1 = b;
            3'd3: begin s = int'(a) - int'(b); r.carry = (s < 0); if (s < 0) s += 256; r.o1 = 8'(s); end
            3'd4: r.o1 = a ^ b;
            3'd5: r.o1 = a & b;
            3'd6: r.o1 = a | b;
            default: r.illegal = 1'b1;
        endcase
        r.zero = (r.o1 == 8'h00);
        return r;
    endfunction

    always @(negedge clock) begin
        if (clear && out_valid && out_ready) begin
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: got o1=0x%0h required no beat at %0t", o1, $time);
            end else begin
                mon_e = q.pop_front();
                chk("out_o1", 32'(o1), 32'(mon_e.o1));
                chk("out_carry", 32'(carry), 32'(mon_e.carry));
                chk("out_zero", 32'(zero), 32'(mon_e.zero));
                chk("out_illegal", 32'(illegal), 32'(mon_e.illegal));
                n_out++;
            end
        end
    end

    task automatic drive_beat(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                              input alu_res_t ex);
        int w;
        bit acc;
        w   = 0;
        acc = 1'b0;
        i1 = a; i2 = b; opcode = op; in_valid = 1'b1;
        while (!acc) begin
            @(negedge clock);
            if (in_ready) begin
                q.push_back(ex);
                acc = 1'b1;
            end
            @(posedge clock); #1;
            w++;
            if (!acc && w > 500) begin
                fail_now("accept_timeout");
                break;
            end
        end
    endtask

    task automatic drain();
        int w;
        w = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while ((q.size() != 0 || out_valid) && w < 300) begin
            @(posedge clock); #1;
            w++;
        end
        if (w >= 300) fail_now("drain_timeout");
    endtask

    task automatic do_reset();
        clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        q.delete();
        repeat (3) @(posedge clock);
        #3 clear = 1'b1;
        @(posedge clock); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int       n;
        int       acc;
        bit       saw;
        alu_res_t ex;
        logic [7:0] bpa [4];
        logic [7:0] bpb [4];
        logic [2:0] bpo [4];

        tbl[0]  = '{8'hF0, 8'h20, 3'd0, '{8'h10, 1'b1, 1'b0, 1'b0}};
        tbl[1]  = '{8'h05, 8'h05, 3'd3, '{8'h00, 1'b0, 1'b1, 1'b0}};
        tbl[2]  = '{8'h00, 8'h01, 3'd3, '{8'hFF, 1'b1, 1'b0, 1'b0}};
        tbl[3]  = '{8'hAB, 8'hCD, 3'd7, '{8'h00, 1'b0, 1'b1, 1'b1}};
        tbl[4]  = '{8'h5A, 8'hA5, 3'd1, '{8'h5A, 1'b0, 1'b0, 1'b0}};
        tbl[5]  = '{8'h5A, 8'hA5, 3'd2, '{8'hA5, 1'b0, 1'b0, 1'b0}};
        tbl[6]  = '{8'hFF, 8'h0F, 3'd4, '{8'hF0, 1'b0, 1'b0, 1'b0}};
        tbl[7]  = '{8'hF0, 8'h0F, 3'd5, '{8'h00, 1'b0, 1'b1, 1'b0}};
        tbl[8]  = '{8'hF0, 8'h0F, 3'd6, '{8'hFF, 1'b0, 1'b0, 1'b0}};
        tbl[9]  = '{8'hFF, 8'h01, 3'd0, '{8'h00, 1'b1, 1'b1, 1'b0}};
        tbl[10] = '{8'h01, 8'h02, 3'd0, '{8'h03, 1'b0, 1'b0, 1'b0}};
        tbl[11] = '{8'h00, 8'h77, 3'd1, '{8'h00, 1'b0, 1'b1, 1'b0}};

        bpa = '{8'h11, 8'h80, 8'h0F, 8'hAA};
        bpb = '{8'h22, 8'h80, 8'h03, 8'h55};
        bpo = '{3'd0,  3'd0,  3'd3,  3'd6};

        // Reset values while clear is held low.
        #2 clear = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_o1", 32'(o1), 0);
        chk("rst_carry", 32'(carry), 0);
        chk("rst_zero", 32'(zero), 1);
        chk("rst_illegal", 32'(illegal), 0);
`ifdef ALU_PIPE_STATS_EN
        chk("rst_op_count", op_count, 0);
        chk("rst_illegal_count", 32'(illegal_count), 0);
`endif
        repeat (2) @(posedge clock);
        #3 clear = 1'b1;
        @(negedge clock);
        chk("in_ready_before_edge", 32'(in_ready), 0);
        @(posedge clock); #1;
        chk("in_ready_first_edge", 32'(in_ready), 1);

        // Latency of a lone beat with no backpressure.
        out_ready = 1'b1;
        drive_beat(8'hF0, 8'h20, 3'd0, '{8'h10, 1'b1, 1'b0, 1'b0});
        in_valid = 1'b0;
        n = 1;
        while (n < 20) begin
            @(negedge clock);
            if (out_valid) break;
            @(posedge clock); #1;
            n++;
        end
        chk("latency", 32'(n), 32'(STAGES));
        drain();

        // Vector table, back to back.
        foreach (tbl[k]) drive_beat(tbl[k].a, tbl[k].b, tbl[k].op, tbl[k].ex);
        drain();
        chk("table_beats_out", 32'(n_out), 13);

        // Backpressure: only STAGES beats fit with out_ready low.
        out_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 6; c++) begin
            i1 = bpa[acc]; i2 = bpb[acc]; opcode = bpo[acc]; in_valid = 1'b1;
            @(negedge clock);
            if (in_ready) begin
                q.push_back(model(bpa[acc], bpb[acc], bpo[acc]));
                acc++;
            end
            @(posedge clock); #1;
        end
        in_valid = 1'b0;
        chk("bp_accepted", 32'(acc), 32'(STAGES));
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            chk("bp_in_ready", 32'(in_ready), 0);
            chk("bp_hold_valid", 32'(out_valid), 1);
            chk("bp_hold_o1", 32'(o1), 32'h33);
        end
        @(posedge clock); #1;
        out_ready = 1'b1;
        for (int k = 2; k < 4; k++) drive_beat(bpa[k], bpb[k], bpo[k], model(bpa[k], bpb[k], bpo[k]));
        drain();
        chk("bp_beats_out", 32'(n_out), 17);

        // Illegal opcode and its statistics.
        do_reset();
        out_ready = 1'b1;
        drive_beat(8'h3C, 8'hC3, 3'd7, '{8'h00, 1'b0, 1'b1, 1'b1});
        drain();
`ifdef ALU_PIPE_STATS_EN
        chk("illegal_count", 32'(illegal_count), 1);
        chk("op_count_one", op_count, 1);
`endif

        // Random stream with random backpressure.
        do_reset();
        n_out  = 0;
        rnd_on = 1'b1;
        fork
            begin
                while (rnd_on) begin
                    @(posedge clock); #1;
                    if (rnd_on) out_ready = 1'($urandom_range(0, 1));
                end
            end
        join_none
        for (int k = 0; k < 100; k++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            logic [2:0] ro;
            ra = 8'($urandom);
            rb = 8'($urandom);
            ro = 3'($urandom_range(0, 7));
            ex = model(ra, rb, ro);
            drive_beat(ra, rb, ro, ex);
        end
        rnd_on = 1'b0;
        drain();
        chk("random_beats_out", 32'(n_out), 100);
`ifdef ALU_PIPE_STATS_EN
        chk("op_count_100", op_count, 100);
`endif

        // Reset with two beats in flight.
        out_ready = 1'b0;
        drive_beat(8'h12, 8'h34, 3'd0, model(8'h12, 8'h34, 3'd0));
        drive_beat(8'h56, 8'h78, 3'd4, model(8'h56, 8'h78, 3'd4));
        in_valid = 1'b0;
        @(negedge clock);
        chk("pre_clear_valid", 32'(out_valid), 1);
        #2 clear = 1'b0;
        #1;
        chk("clear_out_valid", 32'(out_valid), 0);
        chk("clear_in_ready", 32'(in_ready), 0);
        chk("clear_zero", 32'(zero), 1);
        q.delete();
        @(posedge clock);
        #3 clear = 1'b1;
        out_ready = 1'b1;
        saw = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            if (out_valid) saw = 1'b1;
        end
        chk("no_stale_beat", 32'(saw), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
